// File: rtl/clock_rst_seq.sv
// Post-PLL reset sequencer with per-channel divided clock-enables, running in the clk_pix domain.
// Optional lock-loss event counter (loss_count) when CLOCK_RST_SEQ_LOSS_CNT_EN is defined.
module clock_rst_seq #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                      clk_pix,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic [CHANNELS*DIV_W-1:0] div,
    input  logic                      lock_lost_clr,
    output logic                      rst_out,
    output logic                      ready,
    output logic [CHANNELS-1:0]       ce,
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
    output logic                      lock_lost,
    output logic [7:0]                loss_count
`else
    output logic                      lock_lost
`endif
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_WAIT_LOCK, S_HOLD, S_RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [HC_W-1:0]        r_hold;
    logic [HC_W-1:0]        w_hold_nxt;
    logic                   w_loss;
    logic                   r_lock_lost;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= S_WAIT_LOCK;
            r_hold  <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Lock loss is tested before the hold countdown so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_loss      = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = HC_W'(HOLD_CYCLES - 1);
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_loss      = 1'b1;
                end else if (r_hold == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_loss      = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT_LOCK;
        endcase
    end

    assign rst_out = (r_state != S_RUN);
    assign ready   = (r_state == S_RUN);

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst)
            r_lock_lost <= 1'b0;
        else if (w_loss)
            r_lock_lost <= 1'b1;
        else if (lock_lost_clr)
            r_lock_lost <= 1'b0;
    end

    assign lock_lost = r_lock_lost;

`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst)
            r_loss_cnt <= 8'd0;
        else if (w_loss) begin
            if (r_loss_cnt != 8'hFF)
                r_loss_cnt <= r_loss_cnt + 8'd1;
        end else if (lock_lost_clr)
            r_loss_cnt <= 8'd0;
    end

    assign loss_count = r_loss_cnt;
`endif

    // Counters sit at 0 until RUN, so every channel pulses on the first ready cycle.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_W-1:0] w_div;
        logic [DIV_W-1:0] w_lim;
        logic [DIV_W-1:0] r_cnt;

        assign w_div = div[g*DIV_W +: DIV_W];
        assign w_lim = (w_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : w_div - 1'b1;

        always_ff @(posedge clk_pix or posedge rst) begin
            if (rst)
                r_cnt <= '0;
            else if (r_state != S_RUN)
                r_cnt <= '0;
            else if (r_cnt >= w_lim)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end

        assign ce[g] = (r_state == S_RUN) && (r_cnt == '0);
    end

endmodule

// File: tb/tb_clock_rst_seq.sv
// Randomized bench for clock_rst_seq against a lock-run-length reference model.
module tb_clock_rst_seq;

    localparam int CH = 2;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int HC = 16;
    localparam int VW = 11 + CH;

    logic              clk_pix = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic [CH*DW-1:0]  div;
    logic              lock_lost_clr;
    logic              rst_out;
    logic              ready;
    logic [CH-1:0]     ce;
    logic              lock_lost;
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
    logic [7:0]        loss_count;
`endif

    always #5 clk_pix = ~clk_pix;

    clock_rst_seq #(.CHANNELS(CH), .DIV_W(DW), .SYNC_STAGES(SS), .HOLD_CYCLES(HC)) dut (
        .clk_pix      (clk_pix),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .div          (div),
        .lock_lost_clr(lock_lost_clr),
        .rst_out      (rst_out),
        .ready        (ready),
        .ce           (ce),
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
        .lock_lost    (lock_lost),
        .loss_count   (loss_count)
`else
        .lock_lost    (lock_lost)
`endif
    );

    // Model: m_L counts consecutive edges that saw a synchronised lock.
    // 0 => WAIT_LOCK, 1..HC => HOLD, >HC => RUN.
    bit m_hist[SS];
    int m_L;
    bit m_lost;
    int m_ph[CH];
    int m_lc;
    int total = 0;
    int bad   = 0;

    function automatic int eff(int i);
        int d;
        d = int'(div[i*DW +: DW]);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_hist[k] = 1'b0;
        m_L    = 0;
        m_lost = 1'b0;
        m_lc   = 0;
        for (int i = 0; i < CH; i++) m_ph[i] = 0;
    endtask

    task automatic step();
        bit ls, set, prun, run;
        @(posedge clk_pix);
        if (rst) model_reset();
        else begin
            ls = m_hist[SS-1];
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pll_locked;
            set  = !ls && (m_L > 0);
            prun = m_L > HC;
            m_L  = ls ? m_L + 1 : 0;
            run  = m_L > HC;
            for (int i = 0; i < CH; i++)
                m_ph[i] = (prun && run) ? ((m_ph[i] + 1 >= eff(i)) ? 0 : m_ph[i] + 1) : 0;
            if (set) m_lost = 1'b1;
            else if (lock_lost_clr) m_lost = 1'b0;
            if (set) m_lc = (m_lc < 255) ? m_lc + 1 : 255;
            else if (lock_lost_clr) m_lc = 0;
        end
        #1;
    endtask

    function automatic logic [VW-1:0] got_vec();
        logic [7:0] lc;
        lc = 8'd0;
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
        lc = loss_count;
`endif
        return {lc, rst_out, ready, lock_lost, ce};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [7:0]    lc;
        logic [CH-1:0] c;
        bit            run;
        run = m_L > HC;
        for (int i = 0; i < CH; i++) c[i] = run && (m_ph[i] == 0);
        lc = 8'd0;
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
        lc = 8'(m_lc);
`endif
        return {lc, !run, run, m_lost, c};
    endfunction

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; lock_lost_clr = 1'b0;
        div = {8'd4, 8'd1};
        model_reset();
        repeat (5) begin
            step();
            total++;
            if ({rst_out, ready, ce, lock_lost} !== {1'b1, 1'b0, {CH{1'b0}}, 1'b0}) begin
                bad++;
                $display("FAIL reset_vals got=%b exp=%b", {rst_out, ready, ce, lock_lost}, {1'b1, 1'b0, {CH{1'b0}}, 1'b0});
            end
        end
        @(negedge clk_pix) rst = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL powerup edge=%0d got=%h exp=%h", e, got_vec(), exp_vec());
            end
            total++;
            if (ready !== (e == 19) || rst_out !== (e != 19)) begin
                bad++; $display("FAIL ready_rise edge=%0d got ready=%b rst_out=%b", e, ready, rst_out);
            end
        end
    endtask

    task automatic test_dividers();
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL div_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            total++;
            if (ce[0] !== 1'b1 || ce[1] !== (k % 4 == 0)) begin
                bad++; $display("FAIL div_pattern k=%0d got ce=%b exp ce1=%b", k, ce, (k % 4 == 0));
            end
        end
        div[7:0] = 8'd0;
        repeat (8) begin
            step();
            total++;
            if (ce[0] !== 1'b1 || got_vec() !== exp_vec()) begin
                bad++; $display("FAIL div_zero got=%h exp=%h", got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_div_change();
        bit found;
        found = 1'b0;
        div[15:8] = 8'd10;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL divchg_pre got=%h exp=%h", got_vec(), exp_vec());
            end
            if (m_ph[1] == 7) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL divchg_timeout got no cnt=7 exp cnt=7 within 40 cycles");
        end
        div[15:8] = 8'd3;
        for (int j = 0; j <= 9; j++) begin
            step();
            total++;
            if (ce[1] !== (j % 3 == 0) || got_vec() !== exp_vec()) begin
                bad++; $display("FAIL divchg_wrap j=%0d got ce1=%b exp=%b vec=%h model=%h", j, ce[1], (j % 3 == 0), got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL loss_model e=%0d got=%h exp=%h", e, got_vec(), exp_vec());
            end
            total++;
            if (ready !== (e == 1 || e == 19) || (e >= 2 && (lock_lost !== 1'b1 || (e < 19 && (ce !== '0 || rst_out !== 1'b1))))) begin
                bad++; $display("FAIL loss_seq e=%0d got ready=%b lost=%b ce=%b rst_out=%b", e, ready, lock_lost, ce, rst_out);
            end
        end
        lock_lost_clr = 1'b1;
        step();
        lock_lost_clr = 1'b0;
        total++;
        if (lock_lost !== 1'b0 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL loss_clr got lost=%b exp=0", lock_lost);
        end
    endtask

    task automatic test_hold_glitch();
        bit found, saw_set;
        found = 1'b0; saw_set = 1'b0;
        pll_locked = 1'b0;
        repeat (3) step();
        lock_lost_clr = 1'b1; pll_locked = 1'b1;
        step();
        lock_lost_clr = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL glitch_pre got=%h exp=%h", got_vec(), exp_vec());
            end
            if (m_L == HC - 5) found = 1'b1;
        end
        total++;
        if (!found || lock_lost !== 1'b0) begin
            bad++; $display("FAIL glitch_setup got found=%b lost=%b exp found=1 lost=0", found, lock_lost);
        end
        pll_locked = 1'b0;
        for (int n = 0; n < 6; n++) begin
            lock_lost_clr = (m_hist[SS-1] == 1'b0) && (m_L > 0);
            step();
            if (lock_lost_clr) saw_set = 1'b1;
            lock_lost_clr = 1'b0;
            pll_locked = 1'b1;
            total++;
            if (ready !== 1'b0 || got_vec() !== exp_vec() || (saw_set && lock_lost !== 1'b1)) begin
                bad++; $display("FAIL glitch n=%0d got ready=%b lost=%b vec=%h exp=%h", n, ready, lock_lost, got_vec(), exp_vec());
            end
        end
        total++;
        if (!saw_set) begin
            bad++; $display("FAIL glitch_set got no loss edge exp one");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            pll_locked    = ($urandom_range(0, 39) != 0);
            lock_lost_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0)
                for (int i = 0; i < CH; i++) div[i*DW +: DW] = 8'($urandom_range(0, 6));
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL random n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
            end
        end
        pll_locked = 1'b1; lock_lost_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL async_pre got=%h exp=%h", got_vec(), exp_vec());
            end
            if (m_L > HC + 2) found = 1'b1;
        end
        total++;
        if (!found || ready !== 1'b1) begin
            bad++; $display("FAIL async_run got ready=%b exp=1", ready);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({rst_out, ready, ce, lock_lost} !== {1'b1, 1'b0, {CH{1'b0}}, 1'b0}) begin
            bad++; $display("FAIL async_rst got=%b exp=%b", {rst_out, ready, ce, lock_lost}, {1'b1, 1'b0, {CH{1'b0}}, 1'b0});
        end
        step();
        @(negedge clk_pix) rst = 1'b0;
`ifdef CLOCK_RST_SEQ_LOSS_CNT_EN
        for (int n = 0; n < 700; n++) begin
            pll_locked = n[0];
            step();
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL losscnt n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
            end
        end
        total++;
        if (loss_count !== 8'd255) begin
            bad++; $display("FAIL losscnt_sat got=%0d exp=255", loss_count);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (loss_count !== 8'd0) begin
            bad++; $display("FAIL losscnt_rst got=%0d exp=0", loss_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_dividers();
        test_div_change();
        test_lock_loss();
        test_hold_glitch();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
